// File: rtl/vector_stream_pkg.sv
// Shared types and defaults for the vector output streamer: stream FSM states and index-width helper.
// Pure declarations, no latency or flow control of its own.
package vector_stream_pkg;

  localparam int DEF_VECTOR_SIZE  = 6;
  localparam int DEF_OUTPUT_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SEND, DONE} stream_state_t;

  // Never returns 0 so single-entry configurations still get a legal vector width.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head (rdata), one-cycle write-to-visible latency.
// Backpressure: push is refused when full unless a pop retires the head on the same edge.
module sync_fifo
  import vector_stream_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [lane_idx_w(DEPTH):0] level
);

  localparam int AW = lane_idx_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_push;
  logic             do_pop;

  // Counters carry one extra bit so full and empty are distinguishable with DEPTH a power of two.
  assign level   = wr_cnt - rd_cnt;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vector_output_streamer.sv
// Captures CPU output vectors into a FIFO and streams them lane by lane on a valid/ready byte port.
// Capture edge N -> streamValid after N+1; stalled beats hold stable; vectors arriving while full are dropped.
module vector_output_streamer
  import vector_stream_pkg::*;
#(
  parameter int VECTOR_SIZE  = DEF_VECTOR_SIZE,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int COUNT_WIDTH  = 24,
  parameter int LANE_ORDER   = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
  input  logic                                outFlag,
  input  logic                                enable,
  input  logic [COUNT_WIDTH-1:0]              expectedCount,
  output logic [OUTPUT_WIDTH-1:0]             streamData,
  output logic [lane_idx_w(VECTOR_SIZE)-1:0]  streamLane,
  output logic                                streamLast,
  output logic                                streamValid,
  input  logic                                streamReady,
  output logic [lane_idx_w(FIFO_DEPTH):0]     level,
  output logic                                overflow,
  output logic [COUNT_WIDTH-1:0]              capturedCount,
  output logic                                done
);

  localparam int            LW       = lane_idx_w(VECTOR_SIZE);
  localparam int            LVW      = lane_idx_w(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LAST_POS = LW'(VECTOR_SIZE - 1);
  localparam logic [LVW-1:0] LVL_ONE = LVW'(1);

  stream_state_t                       state, state_nxt;
  logic [LW-1:0]                       lane_cnt, lane_cnt_nxt, true_lane;
  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] head;
  logic [OUTPUT_WIDTH-1:0]             lanes [VECTOR_SIZE];
  logic fifo_full, fifo_empty, cap_closed, cap_req, push_ok, beat, last_beat, sending;

  assign cap_closed = (expectedCount != '0) && (capturedCount == expectedCount);
  assign cap_req    = outFlag && enable && !cap_closed;
  assign sending    = (state == SEND);
  assign beat       = sending && streamReady;
  assign last_beat  = beat && (lane_cnt == LAST_POS);
  assign push_ok    = cap_req && (!fifo_full || last_beat);

  sync_fifo #(
    .WIDTH (VECTOR_SIZE*OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cap_req),
    .pop   (last_beat),
    .wdata (out),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_lane
    assign lanes[k] = head[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  // lane_cnt is the position in send order; true_lane maps it back to the bus lane.
  assign true_lane   = (LANE_ORDER != 0) ? (LAST_POS - lane_cnt) : lane_cnt;
  assign streamValid = sending;
  assign streamData  = sending ? lanes[true_lane] : '0;
  assign streamLane  = sending ? true_lane : '0;
  assign streamLast  = sending && (lane_cnt == LAST_POS);
  assign done        = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      capturedCount <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push_ok && !(&capturedCount)) capturedCount <= capturedCount + 1'b1;
      if (cap_req && !push_ok)          overflow      <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      lane_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt    = SEND;
          lane_cnt_nxt = '0;
        end
      end
      SEND: begin
        if (last_beat) begin
          lane_cnt_nxt = '0;
          // Another vector remains after this pop (or arrives on this edge): continue without a bubble.
          if ((level != LVL_ONE) || push_ok) state_nxt = SEND;
          else if (cap_closed)               state_nxt = DONE;
          else                               state_nxt = IDLE;
        end else if (beat) begin
          lane_cnt_nxt = lane_cnt + 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
